// File: rtl/jk_pkg.sv
// Shared definitions for the JK flip-flop bank: mode encoding and next-state rule.
package jk_pkg;

  // Modes are encoded as {j, k}.
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Next state of one JK bit given its {j, k} mode and present state.
  function automatic logic jk_next(input logic [1:0] mode, input logic q);
    logic nxt;
    nxt = q;
    case (mode)
      JK_HOLD:   nxt = q;
      JK_RESET:  nxt = 1'b0;
      JK_SET:    nxt = 1'b1;
      JK_TOGGLE: nxt = ~q;
      default:   nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_ff_bit.sv
// One JK flip-flop bit with asynchronous, active-high reset to rst_val.
module jk_ff_bit
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  input  logic rst_val,
  output logic q
);

  // State register: reset wins over any clock edge; otherwise apply the JK rule.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= rst_val;
    end else begin
      q <= jk_next({j, k}, q);
    end
  end

endmodule

// File: rtl/jk_ff.sv
// Bank of WIDTH independent JK flip-flops with a shared clock and async reset.
// qn is derived combinationally from q so it is the exact complement at all times.
module jk_ff
  import jk_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);

  // One flip-flop per bit; bits never interact.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff_bit u_bit (
      .clk     (clk),
      .rst     (rst),
      .j       (j[i]),
      .k       (k[i]),
      .rst_val (RESET_VALUE[i]),
      .q       (q[i])
    );
  end

  // Complement output, no extra state.
  assign qn = ~q;

endmodule

// File: tb/tb_jk_ff.sv
// Bench for jk_ff: a single-bit instance and a 4-bit instance with a non-zero
// reset value. Drivers push hand-computed expected q per edge; monitors pop
// and compare after each rising edge, and also track a jk_next reference.
module tb_jk_ff;
  import jk_pkg::*;

  // Clock and reset block: rising edges at 5, 15, 25, ...
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, j1, k1, q1, qn1;
  logic       rst4;
  logic [3:0] j4, k4, q4, qn4;

  jk_ff #(.WIDTH(1), .RESET_VALUE(1'b0)) dut1 (
    .clk (clk), .rst (rst1), .j (j1), .k (k1), .q (q1), .qn (qn1)
  );

  jk_ff #(.WIDTH(4), .RESET_VALUE(4'b1010)) dut4 (
    .clk (clk), .rst (rst4), .j (j4), .k (k4), .q (q4), .qn (qn4)
  );

  logic [3:0] exp_q[$];
  logic [3:0] exp4_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp,
                       input logic [3:0] jv, input logic [3:0] kv);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t j=%b k=%b actual=%b expected=%b", name, $time, jv, kv, act, exp);
    end
  endtask

  // Driver tasks: change inputs on the falling edge, push the value q must
  // hold after the following rising edge.
  task automatic drive1(input logic r, input logic jv, input logic kv, input logic e);
    @(negedge clk);
    rst1 = r;
    j1   = jv;
    k1   = kv;
    exp_q.push_back({3'b000, e});
  endtask

  task automatic drive4(input logic r, input logic [3:0] jv, input logic [3:0] kv,
                        input logic [3:0] e);
    @(negedge clk);
    rst4 = r;
    j4   = jv;
    k4   = kv;
    exp4_q.push_back(e);
  endtask

  // Monitor for the 1-bit instance, with a jk_next reference model.
  logic m1 = 1'b0;
  always @(posedge clk) begin
    logic [3:0] e;
    #1;
    if (rst1) m1 = 1'b0;
    else      m1 = jk_next({j1, k1}, m1);
    check("q1_model", {3'b000, q1}, {3'b000, m1}, {3'b000, j1}, {3'b000, k1});
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("q1", {3'b000, q1}, e, {3'b000, j1}, {3'b000, k1});
      check("qn1", {3'b000, qn1}, {3'b000, ~e[0]}, {3'b000, j1}, {3'b000, k1});
    end
  end

  // Monitor for the 4-bit instance, with a per-bit jk_next reference model.
  logic [3:0] m4 = 4'b1010;
  always @(posedge clk) begin
    logic [3:0] e;
    #1;
    if (rst4) m4 = 4'b1010;
    else for (int i = 0; i < 4; i++) m4[i] = jk_next({j4[i], k4[i]}, m4[i]);
    check("q4_model", q4, m4, j4, k4);
    if (exp4_q.size() > 0) begin
      e = exp4_q.pop_front();
      check("q4", q4, e, j4, k4);
      check("qn4", qn4, ~e, j4, k4);
    end
  end

  initial begin
    rst1 = 1'b1; j1 = 1'b1; k1 = 1'b0;
    rst4 = 1'b1; j4 = 4'b0000; k4 = 4'b0000;

    // Reset applied from time zero without any clock edge.
    #1;
    check("rst_async_q1", {3'b000, q1}, 4'b0000, {3'b000, j1}, {3'b000, k1});
    check("rst_async_qn1", {3'b000, qn1}, 4'b0001, {3'b000, j1}, {3'b000, k1});
    check("rst_async_q4", q4, 4'b1010, j4, k4);
    check("rst_async_qn4", qn4, 4'b0101, j4, k4);

    // Reset dominance over three edges with j=1, k=0.
    repeat (3) drive1(1'b1, 1'b1, 1'b0, 1'b0);

    // Mode sequence after release: 10, 00, 01, 11, 11.
    drive1(1'b0, 1'b1, 1'b0, 1'b1);
    drive1(1'b0, 1'b0, 1'b0, 1'b1);
    drive1(1'b0, 1'b0, 1'b1, 1'b0);
    drive1(1'b0, 1'b1, 1'b1, 1'b1);
    drive1(1'b0, 1'b1, 1'b1, 1'b0);

    // Async reset mid-cycle: set q=1, then assert rst 3 ns after the edge.
    drive1(1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    rst1 = 1'b1;
    #1;
    check("mid_rst_q1", {3'b000, q1}, 4'b0000, {3'b000, j1}, {3'b000, k1});
    check("mid_rst_qn1", {3'b000, qn1}, 4'b0001, {3'b000, j1}, {3'b000, k1});
    drive1(1'b1, 1'b1, 1'b0, 1'b0);

    // Toggle: j=k=1 for 8 edges from q=0 gives a clk/2 waveform.
    for (int i = 0; i < 8; i++) drive1(1'b0, 1'b1, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);

    // Reset rising in the same time step as an edge with j=1, k=0.
    drive1(1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    rst1 = 1'b1;
    drive1(1'b0, 1'b0, 1'b0, 1'b0);

    // 4-bit instance: still held in reset after many edges.
    check("rst_hold_q4", q4, 4'b1010, j4, k4);
    // Modes b3..b0 = reset, toggle, hold, set from 1010.
    drive4(1'b0, 4'b0101, 4'b1100, 4'b0111);
    drive4(1'b0, 4'b0101, 4'b1100, 4'b0011);
    drive4(1'b0, 4'b0000, 4'b0000, 4'b0011);

    // Drain with a bounded wait.
    for (int n = 0; n < 20 && (exp_q.size() > 0 || exp4_q.size() > 0); n++) @(negedge clk);
    if (exp_q.size() > 0 || exp4_q.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout pending1=%0d pending4=%0d required=0",
               exp_q.size(), exp4_q.size());
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
